wb_sequencer: RTL

Sequences the register-file writeback path: drives the 2-bit writeback mux select, rf write enable and write address for ALU, load and swap instructions.
- Mux select encoding: 00 = alu_result, 01 = dm data, 10 = Rs operand, 11 = Rd operand.
- Swap is a two-write operation. The block holds the operand latches so both writes use the pre-swap values.
- Sits between ctrl and rf, replacing ctrl's direct wb_sel/rf_we drive.

---
 rtl/wb_sequencer_if.sv | 29 ++
 rtl/wb_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer_if.sv
// Writeback sequencer bus: request from ctrl, load handshake from dm, writeback controls to rf.
interface wb_sequencer_if #(
  parameter int unsigned RA_W = 4
);
  logic            start;
  logic [1:0]      op;
  logic [RA_W-1:0] rs_addr;
  logic [RA_W-1:0] rd_addr;
  logic            load_rdy;
  logic [1:0]      wb_sel;
  logic            rf_we;
  logic [RA_W-1:0] wr_addr;
  logic            rab_hold;
  logic            busy;
  logic            done;
  logic            err;

  // Requester side (ctrl + dm)
  modport master (
    output start, op, rs_addr, rd_addr, load_rdy,
    input  wb_sel, rf_we, wr_addr, rab_hold, busy, done, err
  );

  // Sequencer side
  modport slave (
    input  start, op, rs_addr, rd_addr, load_rdy,
    output wb_sel, rf_we, wr_addr, rab_hold, busy, done, err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Register-file writeback sequencer for ALU, load and two-write swap instructions.
// Outputs are registered: they are decoded from the next state and next latched
// operands, so they line up with the state register cycle by cycle.
module wb_sequencer #(
  parameter int unsigned RA_W   = 4,
  parameter int unsigned LD_TMO = 8
) (
  input logic           clk,
  input logic           rst_f,
  wb_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_TMO - 1);

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_DM  = 2'b01;
  localparam logic [1:0] SEL_RS  = 2'b10;
  localparam logic [1:0] SEL_RD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU_WB,
    S_LD_WAIT,
    S_LD_WB,
    S_SWAP1,
    S_SWAP2,
    S_ERR
  } state_t;

  state_t          state_q, state_n;
  logic [RA_W-1:0] rs_q, rs_n;
  logic [RA_W-1:0] rd_q, rd_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [1:0]      wb_sel_q, wb_sel_n;
  logic            rf_we_q, rf_we_n;
  logic [RA_W-1:0] wr_addr_q, wr_addr_n;
  logic            rab_hold_q, rab_hold_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            err_q, err_n;

  // State, operand latches, load counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q    <= S_IDLE;
      rs_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_sel_q   <= '0;
      rf_we_q    <= 1'b0;
      wr_addr_q  <= '0;
      rab_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      rs_q       <= rs_n;
      rd_q       <= rd_n;
      cnt_q      <= cnt_n;
      wb_sel_q   <= wb_sel_n;
      rf_we_q    <= rf_we_n;
      wr_addr_q  <= wr_addr_n;
      rab_hold_q <= rab_hold_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  // Next-state transitions, then output decode of the state being entered
  always_comb begin
    state_n    = state_q;
    rs_n       = rs_q;
    rd_n       = rd_q;
    cnt_n      = cnt_q;
    wb_sel_n   = SEL_ALU;
    rf_we_n    = 1'b0;
    wr_addr_n  = '0;
    rab_hold_n = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rs_n  = bus.rs_addr;
          rd_n  = bus.rd_addr;
          cnt_n = '0;
          case (bus.op)
            OP_ALU:  state_n = S_ALU_WB;
            OP_LOAD: state_n = S_LD_WAIT;
            OP_SWAP: state_n = S_SWAP1;
            default: state_n = S_ERR;
          endcase
        end
      end
      S_LD_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (bus.load_rdy) begin
          state_n = S_LD_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_n = S_ERR;
        end
      end
      S_SWAP1: begin
        state_n = (rs_q != rd_q) ? S_SWAP2 : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
    case (state_n)
      S_ALU_WB: begin
        rf_we_n   = 1'b1;
        wb_sel_n  = SEL_ALU;
        wr_addr_n = rd_n;
        done_n    = 1'b1;
      end
      S_LD_WAIT: begin
        wb_sel_n = SEL_DM;
      end
      S_LD_WB: begin
        rf_we_n   = 1'b1;
        wb_sel_n  = SEL_DM;
        wr_addr_n = rd_n;
        done_n    = 1'b1;
      end
      S_SWAP1: begin
        rab_hold_n = 1'b1;
        wb_sel_n   = SEL_RD;
        wr_addr_n  = rs_n;
        rf_we_n    = (rs_n != rd_n);
        done_n     = (rs_n == rd_n);
      end
      S_SWAP2: begin
        rab_hold_n = 1'b1;
        rf_we_n    = 1'b1;
        wb_sel_n   = SEL_RS;
        wr_addr_n  = rd_n;
        done_n     = 1'b1;
      end
      S_ERR: begin
        err_n  = 1'b1;
        done_n = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.wb_sel   = wb_sel_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.rab_hold = rab_hold_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
